// File: rtl/stream_arb2x1.sv
// Two-input round-robin stream arbiter with a registered output stage.
// Optional saturating grant counters are enabled by defining STREAM_ARB_CNT_EN.
//
// state | meaning
// PRI0  | source 0 preferred when both are valid
// PRI1  | source 1 preferred when both are valid
module stream_arb2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel
`ifdef STREAM_ARB_CNT_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    pri_t pri_q;
    pri_t pri_d;
    logic load_en;
    logic grant_vld;
    logic grant_idx;
    logic take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q <= PRI0;
        end else begin
            pri_q <= pri_d;
        end
    end

    always_comb begin
        load_en   = !out_valid || out_ready;
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        pri_d     = pri_q;
        if (in0_valid && in1_valid) begin
            grant_vld = 1'b1;
            grant_idx = (pri_q == PRI1);
        end else if (in0_valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
        end else if (in1_valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
        end
        take      = load_en && grant_vld;
        in0_ready = take && !grant_idx;
        in1_ready = take && grant_idx;
        // Hand preference to the source that just lost.
        if (take) begin
            pri_d = grant_idx ? PRI0 : PRI1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= 1'b0;
            out_valid <= 1'b0;
        end else if (take) begin
            out_data  <= grant_idx ? in1_data : in0_data;
            out_sel   <= grant_idx;
            out_valid <= 1'b1;
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_ARB_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= 16'h0000;
            grant_cnt1 <= 16'h0000;
        end else begin
            if (in0_ready && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (in1_ready && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_arb2x1.sv
// Directed testbench for stream_arb2x1: reset, alternation, stall, single source,
// reset mid-operation, drain, and (with STREAM_ARB_CNT_EN) grant counters.
module tb_stream_arb2x1;

    logic       clk;
    logic       rst;
    logic [7:0] in0_data;
    logic       in0_valid;
    logic       in0_ready;
    logic [7:0] in1_data;
    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sel;
`ifdef STREAM_ARB_CNT_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    stream_arb2x1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
`ifdef STREAM_ARB_CNT_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in0_data  = 8'h00;
        in0_valid = 1'b0;
        in1_data  = 8'h00;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_sel", {31'd0, out_sel}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // single word from source 0
        in0_valid = 1'b1;
        in0_data  = 8'hA5;
        out_ready = 1'b1;
        #1;
        check("t1_in0_ready", {31'd0, in0_ready}, 32'd1);
        check("t1_in1_ready", {31'd0, in1_ready}, 32'd0);
        tick();
        in0_valid = 1'b0;
        check("t1_data", {24'd0, out_data}, 32'h0A5);
        check("t1_sel", {31'd0, out_sel}, 32'd0);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        // nothing valid, sink draining: valid drops, data/sel hold
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_data", {24'd0, out_data}, 32'h0A5);

        // alternation from PRI0
        do_reset();
        in0_data  = 8'h10;
        in1_data  = 8'h20;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("alt_sel", {31'd0, out_sel}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check("alt_data", {24'd0, out_data}, (i % 2 == 0) ? 32'h10 : 32'h20);
            check("alt_valid", {31'd0, out_valid}, 32'd1);
        end

        // sink stall holding 8'h33
        do_reset();
        in1_valid = 1'b0;
        in0_data  = 8'h33;
        in0_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in0_data  = 8'h10;
        in1_data  = 8'h20;
        in1_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_in0_ready", {31'd0, in0_ready}, 32'd0);
            check("stall_in1_ready", {31'd0, in1_ready}, 32'd0);
            tick();
            check("stall_data", {24'd0, out_data}, 32'h33);
        end
        out_ready = 1'b1;
        #1;
        check("stall_ptr_in1_ready", {31'd0, in1_ready}, 32'd1);
        check("stall_ptr_in0_ready", {31'd0, in0_ready}, 32'd0);
        tick();
        check("stall_after_data", {24'd0, out_data}, 32'h20);
        check("stall_after_sel", {31'd0, out_sel}, 32'd1);

        // only source 1 for three words
        do_reset();
        in0_valid = 1'b0;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in1_data = 8'(i);
            #1;
            check("s1_in1_ready", {31'd0, in1_ready}, 32'd1);
            check("s1_in0_ready", {31'd0, in0_ready}, 32'd0);
            tick();
            check("s1_data", {24'd0, out_data}, i);
            check("s1_sel", {31'd0, out_sel}, 32'd1);
        end
        in0_valid = 1'b1;
        in0_data  = 8'h44;
        #1;
        check("s1_then_in0_ready", {31'd0, in0_ready}, 32'd1);
        tick();
        check("s1_then_data", {24'd0, out_data}, 32'h44);
        check("s1_then_sel", {31'd0, out_sel}, 32'd0);

        // reset while holding a word with pointer at PRI1
        do_reset();
        in1_valid = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 8'h55;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        in1_valid = 1'b1;
        in1_data  = 8'h66;
        #1;
        check("mid_rst_in0_ready", {31'd0, in0_ready}, 32'd1);
        tick();
        check("mid_rst_no_xfer", {31'd0, out_valid}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rel_in0_ready", {31'd0, in0_ready}, 32'd1);
        tick();
        check("mid_rel_sel", {31'd0, out_sel}, 32'd0);
        check("mid_rel_data", {24'd0, out_data}, 32'h55);

`ifdef STREAM_ARB_CNT_EN
        do_reset();
        check("cnt0_rst", {16'd0, grant_cnt0}, 32'd0);
        check("cnt1_rst", {16'd0, grant_cnt1}, 32'd0);
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        in1_valid = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        check("cnt0_5", {16'd0, grant_cnt0}, 32'd5);
        check("cnt1_3", {16'd0, grant_cnt1}, 32'd3);
        for (int i = 0; i < 70000; i++) tick();
        check("cnt0_sat", {16'd0, grant_cnt0}, 32'h0000FFFF);
        check("cnt1_hold", {16'd0, grant_cnt1}, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
